// File: rtl/spell_mem_pkg.sv
// Shared definitions for the SPELL memory/IO bus: master FSM states, responder
// register map and fixed response data values.
package spell_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] REG_PIN  = 8'h36;
  localparam logic [7:0] REG_DDR  = 8'h37;
  localparam logic [7:0] REG_PORT = 8'h38;

  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
  localparam logic [7:0] STORE_DATA   = 8'h00;

endpackage

// File: rtl/spell_mem_master.sv
// SPELL bus initiator: takes one load/store from the core, runs a select/addr/data
// bus cycle against the mem_io responder and returns one response (or a timeout).
module spell_mem_master
  import spell_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       mem_select,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_data_ready
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          write_q;
  logic          accept;
  logic          first_cycle;
  logic          ready_hit;
  logic          timeout_hit;

  assign accept      = (state == IDLE) && cmd_valid;
  // The timer is zero only in the first BUS cycle, where a ready left over from
  // the previous access must not be taken as this access's completion.
  assign first_cycle = (timer == '0);
  assign ready_hit   = (state == BUS) && !first_cycle && mem_data_ready;
  assign timeout_hit = (state == BUS) && !ready_hit && (timer == TIMER_LAST);

  // NOTE: sequential state uses non-blocking assignments with an async reset so
  // that every flop samples pre-edge values and mem_select drops without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = BUS;
      BUS:     if (ready_hit || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    mem_select = 1'b0;
    mem_write  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      // Reset leaves the FSM in IDLE, so gate ready to keep it low during reset.
      IDLE: cmd_ready = rst_n;
      BUS: begin
        mem_select = 1'b1;
        mem_write  = write_q;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      write_q   <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        write_q   <= cmd_write;
        mem_addr  <= cmd_addr;
        mem_wdata <= cmd_wdata;
        timer     <= '0;
      end else if ((state == BUS) && !ready_hit && !timeout_hit) begin
        timer <= timer + TW'(1);
      end

      if (ready_hit) begin
        rsp_rdata <= write_q ? STORE_DATA : mem_rdata;
        rsp_err   <= 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata <= TIMEOUT_DATA;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spell_mem_master.sv
// Bench for spell_mem_master paired with a behavioural mem_io responder; results
// are compared with a register-level reference model of the responder's contents.
module tb_spell_mem_master;
  import spell_mem_pkg::*;

  localparam int TO = 15;

  typedef enum int {R_NORMAL, R_NEVER, R_ALWAYS} rmode_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rsp_rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_select;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_data_ready;

  rmode_t     rmode = R_NORMAL;
  logic [7:0] r_port;
  logic [7:0] r_ddr;
  logic       sel_q;
  logic [7:0] io_out;

  int passes = 0;
  int total  = 0;

  logic [7:0] m_port = 8'h00;
  logic [7:0] m_ddr  = 8'h00;

  always #5 clk = ~clk;

  spell_mem_master #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_select    (mem_select),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_data_ready(mem_data_ready)
  );

  // mem_io responder: ready/data registered one cycle after select; writes act
  // once on the rising edge of select, PIN writes toggle PORT bits.
  assign io_out = r_port;

  always @(posedge clk or negedge rsp_rst_n) begin
    if (!rsp_rst_n) begin
      r_port         <= 8'h00;
      r_ddr          <= 8'h00;
      sel_q          <= 1'b0;
      mem_data_ready <= 1'b0;
      mem_rdata      <= 8'h00;
    end else begin
      sel_q <= mem_select;
      case (rmode)
        R_NEVER:  mem_data_ready <= 1'b0;
        R_ALWAYS: mem_data_ready <= 1'b1;
        default:  mem_data_ready <= mem_select;
      endcase
      case (mem_addr)
        REG_PIN, REG_PORT: mem_rdata <= r_port;
        REG_DDR:           mem_rdata <= r_ddr;
        default:           mem_rdata <= 8'hFF;
      endcase
      if (mem_select && !sel_q && mem_write) begin
        case (mem_addr)
          REG_PIN:  r_port <= r_port ^ mem_wdata;
          REG_DDR:  r_ddr  <= mem_wdata;
          REG_PORT: r_port <= mem_wdata;
          default:  ;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      REG_PIN, REG_PORT: return m_port;
      REG_DDR:           return m_ddr;
      default:           return 8'hFF;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    case (a)
      REG_PIN:  m_port = m_port ^ d;
      REG_DDR:  m_ddr  = d;
      REG_PORT: m_port = d;
      default:  ;
    endcase
  endtask

  // Issue one command, then count cycles after the acceptance edge until rsp_valid.
  task automatic xact(input logic w, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output int lat,
                      output int sel_n, output bit got);
    int wait_n;
    got = 1'b0; lat = 0; sel_n = 0; rd = 8'h00; er = 1'b0; wait_n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);
    for (int n = 1; n <= 40; n++) begin
      if (rsp_valid) begin
        got = 1'b1; lat = n; rd = rsp_rdata; er = rsp_err;
        break;
      end
      if (mem_select) sel_n++;
      @(negedge clk);
    end
  endtask

  task automatic run_cmd(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic [7:0] exp_rd;
    logic       er;
    int         lat;
    int         sel_n;
    bit         got;
    exp_rd = w ? 8'h00 : model_read(a);
    xact(w, a, d, rd, er, lat, sel_n, got);
    if (w) model_write(a, d);
    check({tag, "_got"}, 32'(got), 32'd1);
    check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
    check({tag, "_err"}, 32'(er), 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_sel"}, 32'(sel_n), 32'd2);
  endtask

  logic [7:0] ra;
  logic [7:0] rdv;
  logic       rw;
  logic [7:0] t_rd;
  logic       t_er;
  int         t_lat;
  int         t_sel;
  bit         t_got;
  int         n_rsp;
  int         low_run;
  int         min_gap;
  bit         seen_high;
  bit         prev_sel;
  bit         any_rsp;
  logic [7:0] io_seq [2];

  initial begin
    #1 rst_n = 1'b0; rsp_rst_n = 1'b0;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_select", 32'(mem_select), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_addr_wdata", {16'd0, mem_addr, mem_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rsp_rst_n = 1'b1;
    #1 check("rst_release_ready", 32'(cmd_ready), 32'd1);

    // Store to PORT drives the responder's outputs
    run_cmd("t1_store_port", 1'b1, REG_PORT, 8'hA5);
    check("t1_io_out", 32'(io_out), 32'hA5);

    // DDR round trip and an unmapped load
    run_cmd("t2_store_ddr", 1'b1, REG_DDR, 8'h0F);
    run_cmd("t2_load_ddr", 1'b0, REG_DDR, 8'h00);
    run_cmd("t2_load_unmapped", 1'b0, 8'h40, 8'h00);

    // Ready tied high: first BUS cycle must still be ignored
    rmode = R_ALWAYS;
    run_cmd("t5_ready_high", 1'b0, REG_PORT, 8'h00);
    rmode = R_NORMAL;

    // Back-to-back PIN toggles with cmd_valid held high
    run_cmd("t3_init", 1'b1, REG_PORT, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_PIN; cmd_wdata = 8'h01;
    n_rsp = 0; low_run = 0; min_gap = 99; seen_high = 1'b0; prev_sel = 1'b0;
    io_seq[0] = 8'hEE; io_seq[1] = 8'hEE;
    for (int n = 0; n < 30; n++) begin
      if (mem_select) begin
        if (seen_high && !prev_sel && low_run < min_gap) min_gap = low_run;
        seen_high = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_sel = mem_select;
      if (rsp_valid) begin
        io_seq[n_rsp] = io_out;
        n_rsp++;
        if (n_rsp == 2) begin
          cmd_valid = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    model_write(REG_PIN, 8'h01);
    model_write(REG_PIN, 8'h01);
    check("t3_rsp_count", 32'(n_rsp), 32'd2);
    check("t3_select_gap", 32'(min_gap), 32'd2);
    check("t3_io_first", 32'(io_seq[0]), 32'h01);
    check("t3_io_second", 32'(io_seq[1]), 32'h00);

    // Missing responder: timeout after TO select-high cycles
    rmode = R_NEVER;
    xact(1'b0, REG_PORT, 8'h00, t_rd, t_er, t_lat, t_sel, t_got);
    check("t4_got", 32'(t_got), 32'd1);
    check("t4_sel", 32'(t_sel), 32'(TO));
    check("t4_lat", 32'(t_lat), 32'(TO + 1));
    check("t4_rdata", 32'(t_rd), 32'hFF);
    check("t4_err", 32'(t_er), 32'd1);
    check("t4_resp_select", 32'(mem_select), 32'd0);
    @(negedge clk);
    rmode = R_NORMAL;
    check("t4_ready_back", 32'(cmd_ready), 32'd1);
    check("t4_rsp_valid_one", 32'(rsp_valid), 32'd0);
    check("t4_hold", {23'd0, rsp_err, rsp_rdata}, 32'h1FF);

    // Async reset mid-BUS drops the access without a response
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_DDR;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t6_sel_before", 32'(mem_select), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_sel_drop", 32'(mem_select), 32'd0);
    check("t6_ready_drop", 32'(cmd_ready), 32'd0);
    check("t6_valid_drop", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t6_ready_after", 32'(cmd_ready), 32'd1);
    any_rsp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) any_rsp = 1'b1;
    end
    check("t6_no_response", 32'(any_rsp), 32'd0);
    run_cmd("t6_recover", 1'b0, REG_DDR, 8'h00);

    // Randomized loads/stores against the register model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = REG_PIN;
        1:       ra = REG_DDR;
        2:       ra = REG_PORT;
        default: ra = 8'h40 + 8'($urandom_range(0, 63));
      endcase
      rw  = 1'($urandom_range(0, 1));
      rdv = 8'($urandom);
      run_cmd($sformatf("rnd%0d_%s_%02h", i, rw ? "st" : "ld", ra), rw, ra, rdv);
    end
    check("final_io_out", 32'(io_out), 32'(m_port));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
